// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// MEM_LAT is the memory model's read latency; the arbiter itself never depends on it.
package mem_arb_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int MEM_LAT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant select: D-cache priority, with the I-cache forced in
// once the D-cache has won MAX_DC_STREAK times in a row over a waiting I-cache.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DC_STREAK = 3,
  parameter int STREAK_W      = 2
) (
  input  logic                ic_req,
  input  logic                dc_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output owner_t              grant_owner
);

  logic icStarved;

  always_comb begin
    icStarved   = ic_req && (streak == STREAK_W'(MAX_DC_STREAK));
    grant_valid = ic_req || dc_req;
    grant_owner = (dc_req && !icStarved) ? OWN_DC : OWN_IC;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache word transactions onto the single memory port.
//
//   state | meaning
//   IDLE  | arbitrate pending requests, latch the winner
//   ISSUE | mem_req high until memory accepts (mem_busy low)
//   WAIT  | read outstanding, count toward timeout
//   DONE  | owner's done (and err) pulse for one cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DC_STREAK = 3,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_DC_STREAK + 1);
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);

  arbState_t           state;
  owner_t              owner;
  logic [STREAK_W-1:0] streak;
  logic [WAIT_W-1:0]   waitCnt;
  logic                grantValid;
  owner_t              grantOwner;

  arb_pick #(
    .MAX_DC_STREAK(MAX_DC_STREAK),
    .STREAK_W     (STREAK_W)
  ) uPick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .streak     (streak),
    .grant_valid(grantValid),
    .grant_owner(grantOwner)
  );

  // mem_wr/mem_addr/mem_wdata double as the transaction latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IC;
      streak    <= '0;
      waitCnt   <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grantValid) begin
            owner   <= grantOwner;
            mem_req <= 1'b1;
            waitCnt <= '0;
            state   <= ISSUE;
            if (grantOwner == OWN_DC) begin
              mem_wr    <= dc_wr;
              mem_addr  <= dc_addr;
              mem_wdata <= dc_wdata;
              if (ic_req && (streak != STREAK_W'(MAX_DC_STREAK)))
                streak <= streak + STREAK_W'(1);
              else if (!ic_req)
                streak <= '0;
            end else begin
              mem_wr    <= 1'b0;
              mem_addr  <= ic_addr;
              mem_wdata <= '0;
              streak    <= '0;
            end
          end
        end
        ISSUE: begin
          if (!mem_busy) begin
            mem_req <= 1'b0;
            if (mem_wr) begin
              ic_done <= (owner == OWN_IC);
              dc_done <= (owner == OWN_DC);
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_valid || (waitCnt == WAIT_W'(TIMEOUT - 1))) begin
            ic_done <= (owner == OWN_IC);
            dc_done <= (owner == OWN_DC);
            err     <= !mem_valid;
            if (owner == OWN_IC) ic_rdata <= mem_valid ? mem_rdata : '0;
            else                 dc_rdata <= mem_valid ? mem_rdata : '0;
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration, latency and data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int MAXS    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0, dc_req = 1'b0, dc_wr = 1'b0;
  logic [15:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0;
  logic        ic_done, dc_done, err, mem_req, mem_wr;
  logic [15:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic        mem_busy = 1'b0, mem_valid = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_arbiter #(.MAX_DC_STREAK(MAXS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // memory environment
  int          validAt = -1, busyLeft = 0, busyPer = 0, reqCycles = 0;
  logic [15:0] validData = '0, accAddr = '0, accData = '0, riseAddr = '0, riseData = '0;
  bit          accWr = 0, prevReq = 0, memMute = 0, strayIssue = 0;

  // reference model state
  int          streak = 0;
  logic [15:0] expIcData = '0, expDcData = '0;
  logic [31:0] obsSeq;
  int          obsCnt;
  bit          fDc = 0, fDcWr = 0, fIc = 0;
  logic [15:0] fDcAddr = '0, fDcData = '0, fIcAddr = '0;

  function automatic logic [15:0] memData(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0040) return 16'hBEEF;
    h = a * 16'h9E37;
    return h ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; then act as the memory for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_req && !prevReq) begin
      busyLeft = busyPer; reqCycles = 0; riseAddr = mem_addr; riseData = mem_wdata;
    end
    if (mem_req) reqCycles++;
    mem_busy = mem_req && (busyLeft > 0);
    if (validAt == cyc) begin
      mem_valid = 1'b1; mem_rdata = validData;
    end else if (strayIssue && mem_req) begin
      mem_valid = 1'b1; mem_rdata = 16'hDEAD;
    end else begin
      mem_valid = 1'b0; mem_rdata = 16'($urandom);
    end
    if (mem_req && !mem_busy) begin
      accAddr = mem_addr; accData = mem_wdata; accWr = mem_wr;
      if (!mem_wr && !memMute) begin
        validAt = cyc + MEM_LAT; validData = memData(mem_addr);
      end
    end
    if (mem_busy) busyLeft--;
    prevReq = mem_req;
  endtask

  // Each requester issues its transactions back to back (re-requesting in its
  // done cycle); the model predicts winner, completion cycle, data and err.
  task automatic run(input int nIc, input int nDc, input int busy, input bit mute);
    int remIc, remDc, start, expDone, guard;
    bit icP, dcP, winDc, wr, dcW;
    logic [15:0] icA, dcA, dcD, a;
    remIc = nIc; remDc = nDc; busyPer = busy; memMute = mute;
    obsSeq = '0; obsCnt = 0;
    icA = fIc ? fIcAddr : 16'($urandom);
    dcA = fDc ? fDcAddr : 16'($urandom);
    dcD = fDc ? fDcData : 16'($urandom);
    dcW = fDc ? fDcWr : 1'($urandom_range(0, 1));
    ic_req = (remIc > 0); ic_addr = icA;
    dc_req = (remDc > 0); dc_addr = dcA; dc_wdata = dcD; dc_wr = dcW;
    while (remIc > 0 || remDc > 0) begin
      start = cyc;
      icP = (remIc > 0); dcP = (remDc > 0);
      winDc = dcP && !(icP && streak == MAXS);
      if (winDc && icP) streak = (streak < MAXS) ? streak + 1 : streak;
      else streak = 0;
      wr = winDc && dcW;
      a = winDc ? dcA : icA;
      expDone = start + 2 + busy + (wr ? 0 : (mute ? TIMEOUT : MEM_LAT));
      guard = 0;
      while (!(ic_done || dc_done) && guard < 40) begin
        tick(); guard++;
      end
      chk("done_seen", {31'b0, ic_done | dc_done}, 32'd1);
      if (!(ic_done || dc_done)) begin
        ic_req = 0; dc_req = 0;
        return;
      end
      chk("done_cycle", cyc, expDone);
      chk("done_owner", {ic_done, dc_done}, winDc ? 2'b01 : 2'b10);
      obsSeq[obsCnt] = dc_done; obsCnt++;
      chk("err", err, !wr && mute);
      chk("accept_addr", accAddr, a);
      chk("issue_addr", riseAddr, a);
      chk("mem_wr", accWr, wr);
      chk("req_cycles", reqCycles, busy + 1);
      if (wr) begin
        chk("accept_wdata", accData, dcD);
        chk("issue_wdata", riseData, dcD);
      end
      if (winDc) begin
        if (!wr) begin
          expDcData = mute ? 16'h0 : memData(a);
          chk("dc_rdata", dc_rdata, expDcData);
        end
        chk("ic_rdata_hold", ic_rdata, expIcData);
      end else begin
        expIcData = mute ? 16'h0 : memData(a);
        chk("ic_rdata", ic_rdata, expIcData);
        if (!dcP) chk("dc_rdata_hold", dc_rdata, expDcData);
      end
      if (winDc) begin
        remDc--;
        dcA = 16'($urandom); dcD = 16'($urandom); dcW = 1'($urandom_range(0, 1));
        dc_req = (remDc > 0); dc_addr = dcA; dc_wdata = dcD; dc_wr = dcW;
      end else begin
        remIc--;
        icA = 16'($urandom);
        ic_req = (remIc > 0); ic_addr = icA;
      end
      tick();
      chk("done_pulse_width", {ic_done, dc_done, err}, 3'b000);
    end
    fDc = 0; fIc = 0; memMute = 0;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_ctrl"}, {ic_done, dc_done, err, mem_req, mem_wr}, 5'b0);
    chk({tag, "_ic_rdata"}, ic_rdata, 16'h0);
    chk({tag, "_dc_rdata"}, dc_rdata, 16'h0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'h0);
  endtask

  initial begin
    int anyDone, nI, nD;
    // reset state
    repeat (3) tick();
    chkAllZero("reset");
    #2 rst_n = 1'b1;
    repeat (2) tick();

    // simultaneous reads: D-cache first, I-cache after the DONE/IDLE gap
    run(1, 1, 0, 0);
    chk("simul_order", obsSeq[1:0], 2'b01);

    // starvation bound: D,D,D then I, then D alone
    run(1, 4, 0, 0);
    chk("starve_order", obsSeq[4:0], 5'b10111);
    chk("starve_count", obsCnt, 5);
    // streak cleared: D-cache wins the next contest again
    run(1, 1, 0, 0);
    chk("streak_cleared", obsSeq[1:0], 2'b01);

    // write with two cycles of backpressure
    fDc = 1; fDcWr = 1; fDcAddr = 16'h0100; fDcData = 16'h1234;
    run(0, 1, 2, 0);

    // timeout, then a normal transaction
    run(1, 0, 0, 1);
    run(1, 1, 1, 0);

    // stray mem_valid during IDLE
    tick();
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    tick();
    tick();
    chk("stray_idle_done", {ic_done, dc_done, err}, 3'b000);
    chk("stray_idle_ic_rdata", ic_rdata, expIcData);
    chk("stray_idle_dc_rdata", dc_rdata, expDcData);
    // stray mem_valid during ISSUE
    strayIssue = 1;
    run(1, 1, 2, 0);
    strayIssue = 0;

    // random traffic
    for (int i = 0; i < 20; i++) begin
      nI = $urandom_range(0, 2);
      nD = $urandom_range(0, 3);
      if (nI == 0 && nD == 0) nD = 1;
      run(nI, nD, $urandom_range(0, 3), 0);
    end

    // reset during WAIT with a D-cache read outstanding
    dc_req = 1; dc_wr = 0; dc_addr = 16'h0222; busyPer = 0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chkAllZero("reset_mid_wait");
    dc_req = 0;
    streak = 0; expIcData = '0; expDcData = '0;
    anyDone = 0;
    repeat (2) begin
      tick();
      anyDone += dc_done;
    end
    #2 rst_n = 1'b1;
    repeat (4) begin
      tick();
      anyDone += dc_done;
    end
    chk("no_done_after_reset", anyDone, 0);
    fIc = 1; fIcAddr = 16'h0040;
    run(1, 0, 0, 0);
    chk("post_reset_ic_rdata", ic_rdata, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache miss/fill path and the D-cache miss/fill/writeback path of the pipelined processor.
- Serialises one word transaction at a time and sequences the memory handshake: issue, accept, data return.
- Returns each result to the requester that owns it, with a one-cycle done pulse.
- Sits between the two cache controllers and the memory model, below fetch and memory stages.

Parameters:
- MEM_LAT, 4: cycles from memory accept (mem_req & ~mem_busy) to mem_valid for a read; informational only, used by the bench.
- MAX_DC_STREAK, 3: consecutive D-cache grants allowed while ic_req is pending before I-cache is forced.
- TIMEOUT, 15: cycles in WAIT without mem_valid before an error completion.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_req  in  1  I-cache read request; held until ic_done.
- ic_addr  in  16  I-cache word address; stable while ic_req.
- ic_done  out  1  one-cycle completion pulse to I-cache.
- ic_rdata  out  16  read data; valid when ic_done.
- dc_req  in  1  D-cache request; held until dc_done.
- dc_wr  in  1  1 = write, 0 = read; stable while dc_req.
- dc_addr  in  16  D-cache address.
- dc_wdata  in  16  D-cache write data.
- dc_done  out  1  one-cycle completion pulse to D-cache.
- dc_rdata  out  16  read data; valid when dc_done.
- err  out  1  pulses with done when the transaction timed out.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_busy  in  1  memory cannot accept this cycle.
- mem_valid  in  1  read data valid, one cycle.
- mem_rdata  in  16  memory read data.

Behaviour:
- Reset: rst_n low forces the following immediately, regardless of what is in flight:
  - state IDLE;
  - every output 0, including ic_rdata and dc_rdata;
  - streak counter 0, wait counter 0, owner/addr/data latches 0.
  - An in-flight transaction is abandoned; no done pulse follows.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE arbitration:
  - If dc_req and ic_req are both high, D-cache wins unless streak==MAX_DC_STREAK, in which case I-cache wins.
  - A single requester always wins.
  - On a grant, latch owner, wr (0 for I-cache), addr and wdata, then go to ISSUE.
  - Streak update: a D-cache grant while ic_req is high increments streak (saturating); an I-cache grant clears it; a D-cache grant with ic_req low also clears it.
- ISSUE:
  - mem_req=1 and mem_wr/mem_addr/mem_wdata are driven from the latches.
  - If mem_busy, stay in ISSUE with all outputs held.
  - Else the request is accepted: a write goes to DONE, a read goes to WAIT.
- WAIT:
  - mem_req=0; the wait counter increments each cycle.
  - On mem_valid, capture mem_rdata into the owner's rdata register and go to DONE.
  - If the counter reaches TIMEOUT, go to DONE with err set and rdata=16'h0000.
  - A mem_valid arriving in any state other than WAIT is ignored.
- DONE:
  - The owner's done is 1 for exactly one cycle, together with err if set; then return to IDLE.
  - Requests are not sampled in DONE, so the minimum gap between grants is 1 cycle.
  - The requester must deassert req in its done cycle or issue a new request.
- Latency, uncontended read with mem_busy=0: req seen in IDLE at cycle t; ISSUE at t+1; WAIT from t+2; mem_valid at t+1+MEM_LAT; done at t+2+MEM_LAT.
- Write latency: done at t+2.
- rdata registers hold their value until the next completion for that owner.
- Dropping req mid-transaction does not abort it; done still pulses.
- Only one transaction is ever outstanding; mem_req is never asserted outside ISSUE.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - owner encoding OWN_IC=0, OWN_DC=1;
  - width constant ADDR_W=16.
- One sub-module, arb_pick: combinational priority/starvation select.
  - Inputs: ic_req, dc_req, streak.
  - Outputs: grant_valid, grant_owner.
- The FSM, latches and counters stay in mem_arbiter.

Test Plan:
- Reset mid-WAIT: rst_n low while in WAIT with a dc read outstanding -> all outputs 0 immediately; no dc_done after release; the next ic_req read of 16'h0040 with mem_rdata=16'hBEEF gives ic_done at t+6 and ic_rdata=16'hBEEF.
- Simultaneous requests: ic_req and dc_req read at the same cycle -> D-cache served first (mem_addr=dc_addr); ic served after dc_done plus one DONE/IDLE gap.
- Starvation bound: dc_req held continuously with ic_req high -> exactly 3 D-cache grants, then an I-cache grant, then streak cleared.
- Write with backpressure: dc write of 16'h1234 to 16'h0100 with mem_busy high for 2 cycles -> mem_req held 3 cycles with stable addr/data; dc_done 1 cycle after accept; err=0.
- Timeout: ic read, mem_valid never asserted -> ic_done and err pulse together after 15 WAIT cycles; ic_rdata=0; the next transaction proceeds normally.
- Stray data: mem_valid pulsed during IDLE and during ISSUE -> no done; rdata unchanged.
